// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl_pkg
// Brief    : State encoding and parameter defaults for the trap/return
//            sequencing controller.
// Revision : 1.0
// ============================================================================
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } trap_state_t;

    localparam int unsigned C_XLEN_DEF         = 32;
    localparam int unsigned C_FLUSH_CYCLES_DEF = 2;
    localparam int unsigned C_DRAIN_MAX_DEF    = 16;

endpackage
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Brief    : Turns each trap entry / MRET into one PC redirect: drains data
//            memory, redirects, then holds a fixed-length IF/ID flush.
// Revision : 1.0
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN         = C_XLEN_DEF,
    parameter int unsigned FLUSH_CYCLES = C_FLUSH_CYCLES_DEF,
    parameter int unsigned DRAIN_MAX    = C_DRAIN_MAX_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ex,
    input  logic            i_eret,
    input  logic [XLEN-1:0] i_tvec,
    input  logic [XLEN-1:0] i_epc,
    input  logic            i_mem_busy,
    output logic            o_stall,
    output logic            o_pc_sel,
    output logic [XLEN-1:0] o_pc_target,
    output logic            o_flush,
    output logic            o_busy,
    output logic            o_drain_err,
    output logic [31:0]     o_trap_cnt
);

    localparam logic [7:0]      C_DRAIN_LAST = 8'(DRAIN_MAX - 1);
    localparam logic [2:0]      C_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [XLEN-1:0] C_ALIGN_MASK = ~XLEN'(3);

    trap_state_t     r_state;
    trap_state_t     w_state_nxt;
    logic [XLEN-1:0] r_tgt;
    logic [7:0]      r_drain_cnt;
    logic [2:0]      r_flush_cnt;
    logic [31:0]     r_trap_cnt;
    logic [XLEN-1:0] w_tgt_sel;
    logic            w_event;

    // Events are only honoured in IDLE; anything arriving later comes from
    // instructions that are about to be flushed.
    assign w_event   = (r_state == ST_IDLE) && (i_ex || i_eret);
    assign w_tgt_sel = i_ex ? i_tvec : i_epc;

    always_comb begin
        w_state_nxt = r_state;
        o_stall     = 1'b0;
        o_pc_sel    = 1'b0;
        o_flush     = 1'b0;
        o_drain_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    o_stall     = 1'b1;
                    w_state_nxt = i_mem_busy ? ST_DRAIN : ST_REDIRECT;
                end
            end
            ST_DRAIN: begin
                o_stall = 1'b1;
                if (!i_mem_busy) begin
                    w_state_nxt = ST_REDIRECT;
                end else if (r_drain_cnt == C_DRAIN_LAST) begin
                    w_state_nxt = ST_REDIRECT;
                    o_drain_err = 1'b1;
                end
            end
            ST_REDIRECT: begin
                o_pc_sel    = 1'b1;
                o_flush     = 1'b1;
                w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                o_flush = 1'b1;
                if (r_flush_cnt == 3'd0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The drain counter starts at 1 so the event cycle itself counts toward
    // the timeout, putting the forced redirect at T+DRAIN_MAX.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_tgt       <= '0;
            r_drain_cnt <= '0;
            r_flush_cnt <= '0;
            r_trap_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_event) begin
                r_tgt       <= w_tgt_sel & C_ALIGN_MASK;
                r_drain_cnt <= 8'd1;
            end else if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 8'd1;
            end
            if (r_state == ST_REDIRECT) begin
                r_flush_cnt <= C_FLUSH_LOAD;
            end else if ((r_state == ST_FLUSH) && (r_flush_cnt != 3'd0)) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end
            if (w_event && i_ex) begin
                r_trap_cnt <= r_trap_cnt + 32'd1;
            end
        end
    end

    assign o_pc_target = r_tgt;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_trap_cnt  = r_trap_cnt;

endmodule
`default_nettype wire
